// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// master drives the request side, slave (the subtractor) returns the result.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] difference;
   logic             borrow;
   logic             overflow;

   modport master (
      output start, a, b,
      input  busy, done, difference, borrow, overflow
   );

   modport slave (
      input  start, a, b,
      output busy, done, difference, borrow, overflow
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b: one shared one-bit subtractor cell and a registered borrow,
// LSB first over WIDTH cycles, with start/busy/done handshake and borrow/overflow flags.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   serial_subtractor_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   // Counter must reach WIDTH-1 without wrapping; never narrower than one bit.
   localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic             bor_q, bor_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;

   logic             ai, bi, dbit, bnext;
   logic [WIDTH:0]   res_ext;

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      bor_d    = bor_q;
      cnt_d    = cnt_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;

      ai      = a_sh_q[0];
      bi      = b_sh_q[0];
      dbit    = ai ^ bi ^ bor_q;
      bnext   = (~ai & bi) | (~(ai ^ bi) & bor_q);
      // New difference bit enters at the MSB; works for WIDTH=1 as well.
      res_ext = {dbit, res_sh_q} >> 1;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               a_msb_d = bus.a[WIDTH-1];
               b_msb_d = bus.b[WIDTH-1];
               bor_d   = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            res_sh_d = res_ext[WIDTH-1:0];
            bor_d    = bnext;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               diff_d   = res_ext[WIDTH-1:0];
               borrow_d = bnext;
               ovf_d    = (a_msb_q != b_msb_q) && (res_ext[WIDTH-1] != a_msb_q);
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         bor_q    <= 1'b0;
         cnt_q    <= '0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         bor_q    <= bor_d;
         cnt_q    <= cnt_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == DONE);
   assign bus.difference = diff_q;
   assign bus.borrow     = borrow_q;
   assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH = 1, 8 and 16 sharing clk/rst.
module tb_serial_subtractor;

   typedef struct packed {
      logic        ovf;
      logic        bor;
      logic [15:0] diff;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(1))  if1 ();
   serial_subtractor_if #(.WIDTH(8))  if8 ();
   serial_subtractor_if #(.WIDTH(16)) if16 ();

   serial_subtractor #(.WIDTH(1))  u_w1  (.clk(clk), .rst(rst), .bus(if1.slave));
   serial_subtractor #(.WIDTH(8))  u_w8  (.clk(clk), .rst(rst), .bus(if8.slave));
   serial_subtractor #(.WIDTH(16)) u_w16 (.clk(clk), .rst(rst), .bus(if16.slave));

   int   n_cmp = 0;
   int   n_err = 0;
   int   done1_cnt = 0, done8_cnt = 0, done16_cnt = 0;
   exp_t q1[$], q8[$], q16[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: (a-b) mod 2^w, unsigned borrow, signed overflow.
   function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] m;
      logic [15:0] am, bm, d;
      exp_t        e;
      m      = (17'd1 << w) - 17'd1;
      am     = a & m[15:0];
      bm     = b & m[15:0];
      d      = (am - bm) & m[15:0];
      e.diff = d;
      e.bor  = (am < bm);
      e.ovf  = (am[w-1] != bm[w-1]) && (d[w-1] != am[w-1]);
      return e;
   endfunction

   task automatic score(input string tag, input exp_t e, input logic [15:0] d,
                        input logic bo, input logic ov);
      chk({tag, "_diff"},     32'(d),  32'(e.diff));
      chk({tag, "_borrow"},   32'(bo), 32'(e.bor));
      chk({tag, "_overflow"}, 32'(ov), 32'(e.ovf));
   endtask

   always @(negedge clk) begin
      if (if1.done) begin
         done1_cnt++;
         chk("w1_sb_nonempty", 32'(q1.size() != 0), 32'd1);
         if (q1.size() != 0) score("w1", q1.pop_front(), 16'(if1.difference), if1.borrow, if1.overflow);
      end
      if (if8.done) begin
         done8_cnt++;
         chk("w8_sb_nonempty", 32'(q8.size() != 0), 32'd1);
         if (q8.size() != 0) score("w8", q8.pop_front(), 16'(if8.difference), if8.borrow, if8.overflow);
      end
      if (if16.done) begin
         done16_cnt++;
         chk("w16_sb_nonempty", 32'(q16.size() != 0), 32'd1);
         if (q16.size() != 0) score("w16", q16.pop_front(), if16.difference, if16.borrow, if16.overflow);
      end
   end

   task automatic drive(input int w, input logic s, input logic [15:0] a, input logic [15:0] b);
      case (w)
         1: begin if1.start = s; if1.a = a[0:0]; if1.b = b[0:0]; end
         8: begin if8.start = s; if8.a = a[7:0]; if8.b = b[7:0]; end
         default: begin if16.start = s; if16.a = a; if16.b = b; end
      endcase
   endtask

   task automatic push(input int w, input logic [15:0] a, input logic [15:0] b);
      case (w)
         1:       q1.push_back(model(1, a, b));
         8:       q8.push_back(model(8, a, b));
         default: q16.push_back(model(16, a, b));
      endcase
   endtask

   function automatic logic get_busy(input int w);
      return (w == 1) ? if1.busy : (w == 8) ? if8.busy : if16.busy;
   endfunction

   function automatic logic get_done(input int w);
      return (w == 1) ? if1.done : (w == 8) ? if8.done : if16.done;
   endfunction

   // One start pulse; checks latency, busy length and return to idle.
   task automatic op(input int w, input logic [15:0] a, input logic [15:0] b, input string tag);
      int lat, bcnt;
      @(negedge clk);
      drive(w, 1'b1, a, b);
      push(w, a, b);
      @(negedge clk);
      drive(w, 1'b0, a, b);
      lat  = 1;
      bcnt = int'(get_busy(w));
      while (!get_done(w) && lat < 64) begin
         @(negedge clk);
         lat++;
         bcnt += int'(get_busy(w));
      end
      chk({tag, "_done_latency"}, 32'(lat), 32'(w + 1));
      chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(w + 1));
      @(negedge clk);
      chk({tag, "_busy_after"}, 32'(get_busy(w)), 32'd0);
      chk({tag, "_done_after"}, 32'(get_done(w)), 32'd0);
   endtask

   initial begin
      int c, d1, dc;
      drive(1, 1'b0, 16'h0, 16'h0);
      drive(8, 1'b0, 16'h0, 16'h0);
      drive(16, 1'b0, 16'h0, 16'h0);
      repeat (3) @(negedge clk);
      chk("rst_busy",     32'(if8.busy), 32'd0);
      chk("rst_done",     32'(if8.done), 32'd0);
      chk("rst_diff",     32'(if8.difference), 32'd0);
      chk("rst_borrow",   32'(if8.borrow), 32'd0);
      chk("rst_overflow", 32'(if8.overflow), 32'd0);
      rst = 1'b0;

      op(8, 16'h05, 16'h03, "w8_5m3");
      op(8, 16'h03, 16'h05, "w8_3m5");
      op(8, 16'h80, 16'h01, "w8_80m1");
      op(8, 16'h7F, 16'hFF, "w8_7fmff");

      op(1, 16'h0, 16'h0, "w1_00");
      op(1, 16'h0, 16'h1, "w1_01");
      op(1, 16'h1, 16'h0, "w1_10");
      op(1, 16'h1, 16'h1, "w1_11");

      // Starts during RUN and during DONE must be ignored.
      dc = done8_cnt;
      @(negedge clk);
      drive(8, 1'b1, 16'h10, 16'h01);
      push(8, 16'h10, 16'h01);
      @(negedge clk);
      drive(8, 1'b0, 16'h10, 16'h01);
      repeat (3) @(negedge clk);
      drive(8, 1'b1, 16'hFF, 16'h00);
      @(negedge clk);
      drive(8, 1'b0, 16'hFF, 16'h00);
      c = 0;
      while (!if8.done && c < 64) begin @(negedge clk); c++; end
      drive(8, 1'b1, 16'hFF, 16'h00);
      @(negedge clk);
      drive(8, 1'b0, 16'hFF, 16'h00);
      repeat (12) @(negedge clk);
      chk("rej_done_pulses", 32'(done8_cnt - dc), 32'd1);
      chk("rej_busy_idle",   32'(if8.busy), 32'd0);

      // Asynchronous reset three cycles into RUN.
      @(negedge clk);
      drive(8, 1'b1, 16'h20, 16'h01);
      @(negedge clk);
      drive(8, 1'b0, 16'h20, 16'h01);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy",     32'(if8.busy), 32'd0);
      chk("abort_done",     32'(if8.done), 32'd0);
      chk("abort_diff",     32'(if8.difference), 32'd0);
      chk("abort_borrow",   32'(if8.borrow), 32'd0);
      chk("abort_overflow", 32'(if8.overflow), 32'd0);
      dc = done8_cnt;
      @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      chk("abort_no_done", 32'(done8_cnt - dc), 32'd0);
      op(8, 16'h09, 16'h04, "w8_after_abort");

      // Start coinciding with reset is not accepted.
      @(negedge clk);
      rst = 1'b1;
      drive(8, 1'b1, 16'h01, 16'h00);
      @(negedge clk);
      rst = 1'b0;
      drive(8, 1'b0, 16'h01, 16'h00);
      @(negedge clk);
      chk("rst_start_busy", 32'(if8.busy), 32'd0);

      // Back-to-back with start held high.
      dc = done16_cnt;
      @(negedge clk);
      drive(16, 1'b1, 16'h1234, 16'h0234);
      push(16, 16'h1234, 16'h0234);
      push(16, 16'h0000, 16'h0001);
      @(negedge clk);
      drive(16, 1'b1, 16'h0000, 16'h0001);
      c = 1;
      while (!if16.done && c < 64) begin @(negedge clk); c++; end
      d1 = c;
      @(negedge clk);
      chk("b2b_gap_busy", 32'(if16.busy), 32'd0);
      @(negedge clk);
      chk("b2b_reaccept_busy", 32'(if16.busy), 32'd1);
      drive(16, 1'b0, 16'h0000, 16'h0001);
      c = d1 + 2;
      while (!if16.done && c < 128) begin @(negedge clk); c++; end
      chk("b2b_done_spacing", 32'(c - d1), 32'd18);
      repeat (25) @(negedge clk);
      chk("b2b_done_pulses", 32'(done16_cnt - dc), 32'd2);
      chk("b2b_busy_idle",   32'(if16.busy), 32'd0);

      chk("sb_w1_drained",  32'(q1.size()), 32'd0);
      chk("sb_w8_drained",  32'(q8.size()), 32'd0);
      chk("sb_w16_drained", 32'(q16.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial subtractor computing `a - b` over WIDTH clock cycles with one shared one-bit subtractor cell and a registered borrow. It generalises the combinational one-bit subtractor to arbitrary operand width and adds a start/busy/done handshake, unsigned borrow-out and signed overflow flags. It is intended for area-constrained datapaths where a multi-cycle latency is acceptable.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is 1 or greater.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a subtraction; sampled only while `busy`=0.
- `a` input WIDTH: minuend, captured on the accepting edge.
- `b` input WIDTH: subtrahend, captured on the accepting edge.
- `busy` output 1: high from the cycle after acceptance through the done cycle.
- `done` output 1: one-cycle pulse when the result registers update.
- `difference` output WIDTH: `(a - b) mod 2^WIDTH`.
- `borrow` output 1: 1 when `a < b` unsigned; this is the final borrow out of the MSB.
- `overflow` output 1: signed two's-complement overflow of `a - b`.

## Operation
- The FSM has three states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1; processes one bit per cycle, LSB first.
  - DONE: `busy`=1, `done`=1 for exactly one cycle, then returns to IDLE.
- Acceptance happens on a rising edge with state=IDLE and `start`=1. On that edge:
  - `a` and `b` load into internal shift registers.
  - The borrow flop clears to 0 and the bit counter clears to 0.
  - The FSM moves to RUN.
- Each RUN edge handles current bits `ai`, `bi` and borrow-in `bin`:
  - Difference bit `ai ^ bi ^ bin`, shifted into the MSB of the result shift register.
  - Borrow update `(~ai & bi) | (~(ai ^ bi) & bin)`.
  - Both operand registers shift right by one; the counter increments.
- On the RUN edge that processes bit WIDTH-1:
  - The completed result loads into `difference`.
  - The final borrow loads into `borrow`.
  - `overflow` loads as `(a[W-1] != b[W-1]) & (diff[W-1] != a[W-1])`, using the captured operand MSBs.
  - The FSM moves to DONE.
- `start` is ignored while `busy`=1, including the DONE cycle. An operation in flight is never restarted or corrupted.
- `difference`, `borrow` and `overflow` hold their values until the next operation completes. They do not change during RUN.
- For WIDTH=1 there is exactly one RUN cycle, and the result equals the one-bit subtractor truth table.
- The counter is `$clog2(WIDTH+1)` bits wide, or at least 1 bit, and must not wrap before WIDTH bits are processed.

## Timing
- Reset value of every output is 0: `busy`, `done`, `difference`, `borrow`, `overflow`. FSM resets to IDLE; internal shift registers, counter and borrow flop reset to 0.
- Reset asserted mid-operation aborts immediately and asynchronously. After deassertion the block is in IDLE, and no `done` pulse is emitted for the aborted operation.
- Latency: if `start` is accepted at edge k, the following holds:
  - `busy`=1 after edge k.
  - The result registers update and `done`=1 after edge k+WIDTH.
  - `done`=0 and `busy`=0 after edge k+WIDTH+1.
- Minimum spacing between accepted starts is WIDTH+2 cycles. A `start` held high continuously is accepted at the first edge in IDLE after each DONE.
- `done` is never high for two consecutive cycles. `busy` is high exactly WIDTH+1 cycles per operation.
- `start` asserted during the same cycle as `rst`: reset wins; the operation is not accepted.

## Test plan
- WIDTH=8, a=0x05, b=0x03, start one cycle:
  - `done` 8 cycles after the accepting edge.
  - `difference`=0x02, `borrow`=0, `overflow`=0.
  - `busy` high for 9 cycles.
- WIDTH=8, a=0x03, b=0x05 -> `difference`=0xFE, `borrow`=1, `overflow`=0. Then a=0x80, b=0x01 -> 0x7F, `borrow`=0, `overflow`=1. Then a=0x7F, b=0xFF -> 0x80, `borrow`=1, `overflow`=1.
- WIDTH=1, all four (a,b) pairs:
  - 00 gives diff 0, borrow 0.
  - 01 gives diff 1, borrow 1.
  - 10 gives diff 1, borrow 0.
  - 11 gives diff 0, borrow 0.
  - Each `done` arrives 1 cycle after acceptance.
- Busy rejection, WIDTH=8: start a=0x10, b=0x01; pulse start with a=0xFF, b=0x00 during RUN and during DONE. Required: a single result 0x0F, exactly one `done` pulse, and no second operation.
- Reset mid-operation: assert `rst` 3 cycles into RUN for a=0x20, b=0x01. Required: all outputs 0 immediately, no `done`. After release, a=0x09, b=0x04 gives 0x05.
- Back-to-back, WIDTH=16, with `start` held high: a=0x1234, b=0x0234, then 0x0000 - 0x0001. Required: 0x1000 with borrow 0, then 0xFFFF with borrow 1. `done` pulses are exactly 18 cycles apart, and `busy` drops for exactly one cycle between them.
